// File: rtl/spike_aer_encoder.sv
// Address-event encoder: turns qualified LIF spikes into {slot, timestamp} words buffered in a show-ahead FIFO.
// Optional macro AER_DROP_COUNT_EN adds a saturating drop_count output that also drives overflow.
module spike_aer_encoder #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2,
  parameter int TS_W      = 6,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       slot_valid,
  input  logic [SLOT_W-1:0]          slot_in,
  input  logic                       spike_in,
  input  logic                       frame_tick,
  input  logic                       ev_ready,
  input  logic                       clr_overflow,
  output logic                       ev_valid,
  output logic [SLOT_W-1:0]          ev_slot,
  output logic [TS_W-1:0]            ev_ts,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
`ifdef AER_DROP_COUNT_EN
  , output logic [7:0]               drop_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EV_W  = SLOT_W + TS_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  if (NUM_SLOTS > (1 << SLOT_W)) begin : g_bad_num_slots
    $error("spike_aer_encoder: NUM_SLOTS exceeds 2**SLOT_W");
  end
  if ((DEPTH < 2) || ((1 << PTR_W) != DEPTH)) begin : g_bad_depth
    $error("spike_aer_encoder: DEPTH must be a power of 2 and at least 2");
  end

  logic [EV_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [TS_W-1:0]  ts;
  logic [EV_W-1:0]  wr_data;
  logic [CNT_W-1:0] count_next;
  logic             push_req;
  logic             pop;
  logic             full;
  logic             push;
  logic             drop;

  assign push_req   = slot_valid & spike_in;
  assign pop        = ev_valid & ev_ready;
  assign full       = (fifo_count == FULL);
  assign push       = push_req & (~full | pop);
  assign drop       = push_req & full & ~pop;
  assign wr_data    = {slot_in, ts};
  assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

  // Storage has no reset; validity is tracked entirely by fifo_count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Head registers are preloaded so ev_slot/ev_ts never depend on the write port combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts         <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      ev_valid   <= 1'b0;
      ev_slot    <= '0;
      ev_ts      <= '0;
    end else begin
      if (frame_tick) begin
        ts <= ts + TS_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= count_next;
      ev_valid   <= (count_next != '0);
      if (pop) begin
        if (fifo_count == ONE) begin
          {ev_slot, ev_ts} <= wr_data;
        end else begin
          {ev_slot, ev_ts} <= mem[rd_ptr + PTR_W'(1)];
        end
      end else if ((fifo_count == '0) && push) begin
        {ev_slot, ev_ts} <= wr_data;
      end
    end
  end

`ifdef AER_DROP_COUNT_EN
  // A drop coincident with a clear restarts the count at 1 rather than losing the event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (clr_overflow) begin
      drop_count <= drop ? 8'd1 : 8'd0;
    end else if (drop && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  assign overflow = (drop_count != 8'd0);
`else
  // Sticky flag; a same-cycle drop beats the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Scoreboard bench for spike_aer_encoder: expected events are queued at drive time and checked on pop.
module tb_spike_aer_encoder;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       slot_valid;
  logic [1:0] slot_in;
  logic       spike_in;
  logic       frame_tick;
  logic       ev_ready;
  logic       clr_overflow;
  logic       ev_valid;
  logic [1:0] ev_slot;
  logic [5:0] ev_ts;
  logic [3:0] fifo_count;
  logic       overflow;
`ifdef AER_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif

  logic [7:0] exp_q[$];
  logic [5:0] ts_model;
  logic       ovf_model;
  int         drop_model;
  int         n_cmp = 0;
  int         n_bad = 0;

  spike_aer_encoder #(.NUM_SLOTS(4), .SLOT_W(2), .TS_W(6), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .slot_valid(slot_valid), .slot_in(slot_in),
    .spike_in(spike_in), .frame_tick(frame_tick), .ev_ready(ev_ready),
    .clr_overflow(clr_overflow), .ev_valid(ev_valid), .ev_slot(ev_slot),
    .ev_ts(ev_ts), .fifo_count(fifo_count), .overflow(overflow)
`ifdef AER_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Drives one cycle and advances the reference model; comparisons live in the scenario tasks.
  task automatic step(input logic v, input logic [1:0] s, input logic sp,
                      input logic tk, input logic rd, input logic clr);
    logic dropped;
    slot_valid = v; slot_in = s; spike_in = sp; frame_tick = tk;
    ev_ready = rd; clr_overflow = clr;
    dropped = 1'b0;
    if (rd && exp_q.size() != 0) void'(exp_q.pop_front());
    if (v && sp) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({s, ts_model});
      else dropped = 1'b1;
    end
    if (clr) begin
      ovf_model = dropped;
      drop_model = dropped ? 1 : 0;
    end else if (dropped) begin
      ovf_model = 1'b1;
      if (drop_model < 255) drop_model++;
    end
    if (tk) ts_model = ts_model + 6'd1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    exp_q.delete();
    ts_model = '0; ovf_model = 1'b0; drop_model = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({ev_valid, ev_slot, ev_ts, fifo_count, overflow} !== 14'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs got v=%b s=%0d ts=%0d cnt=%0d ovf=%b want all 0",
               ev_valid, ev_slot, ev_ts, fifo_count, overflow);
    end
  endtask

  task automatic test_single_event();
    step(1, 2'd2, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({ev_valid, ev_slot, ev_ts, fifo_count} !== {1'b1, 2'd2, 6'd0, 4'd1}) begin
        n_bad++;
        $display("[TB] FAIL single_hold[%0d] got v=%b s=%0d ts=%0d cnt=%0d want v=1 s=2 ts=0 cnt=1",
                 i, ev_valid, ev_slot, ev_ts, fifo_count);
      end
      step(0, 2'd3, 1, 0, 0, 0);
    end
    // ev_ready while empty must be harmless
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    n_cmp++;
    if ({ev_valid, fifo_count} !== 5'd0) begin
      n_bad++;
      $display("[TB] FAIL ready_on_empty got v=%b cnt=%0d want v=0 cnt=0", ev_valid, fifo_count);
    end
  endtask

  task automatic test_timestamp();
    int guard;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
    step(1, 2'd1, 1, 1, 0, 0);
    step(1, 2'd0, 1, 0, 0, 0);
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      n_cmp++;
      if ({ev_valid, ev_slot, ev_ts} !== {1'b1, exp_q[0]}) begin
        n_bad++;
        $display("[TB] FAIL ts_drain got v=%b s=%0d ts=%0d want s=%0d ts=%0d",
                 ev_valid, ev_slot, ev_ts, exp_q[0][7:6], exp_q[0][5:0]);
      end
      step(0, 0, 0, 0, 1, 0);
      guard++;
    end
  endtask

  task automatic test_fill_overflow();
    int guard;
    for (int i = 0; i < 8; i++) step(1, 2'(i % 4), 1, 0, 0, 0);
    n_cmp++;
    if ({fifo_count, overflow} !== {4'd8, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL fill8 got cnt=%0d ovf=%b want cnt=8 ovf=0", fifo_count, overflow);
    end
    step(1, 2'd2, 1, 0, 0, 0);
    n_cmp++;
    if ({fifo_count, overflow} !== {4'd8, ovf_model}) begin
      n_bad++;
      $display("[TB] FAIL overflow_set got cnt=%0d ovf=%b want cnt=8 ovf=1", fifo_count, overflow);
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      n_cmp++;
      if ({ev_valid, ev_slot, ev_ts} !== {1'b1, exp_q[0]}) begin
        n_bad++;
        $display("[TB] FAIL fill_drain got v=%b s=%0d ts=%0d want s=%0d ts=%0d",
                 ev_valid, ev_slot, ev_ts, exp_q[0][7:6], exp_q[0][5:0]);
      end
      step(0, 0, 0, 0, 1, 0);
      guard++;
    end
    n_cmp++;
    if ({ev_valid, fifo_count} !== 5'd0) begin
      n_bad++;
      $display("[TB] FAIL drained_empty got v=%b cnt=%0d want v=0 cnt=0", ev_valid, fifo_count);
    end
    step(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL overflow_clear got %b want 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    for (int i = 0; i < 8; i++) step(1, 2'(i % 4), 1, (i == 4) ? 1'b1 : 1'b0, 0, 0);
    n_cmp++;
    if ({ev_valid, ev_slot, ev_ts} !== {1'b1, exp_q[0]}) begin
      n_bad++;
      $display("[TB] FAIL full_head got s=%0d ts=%0d want s=%0d ts=%0d",
               ev_slot, ev_ts, exp_q[0][7:6], exp_q[0][5:0]);
    end
    step(1, 2'd3, 1, 0, 1, 0);
    n_cmp++;
    if ({fifo_count, overflow} !== {4'd8, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL full_pop_push got cnt=%0d ovf=%b want cnt=8 ovf=0", fifo_count, overflow);
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      n_cmp++;
      if ({ev_valid, ev_slot, ev_ts} !== {1'b1, exp_q[0]}) begin
        n_bad++;
        $display("[TB] FAIL b2b_drain got v=%b s=%0d ts=%0d want s=%0d ts=%0d",
                 ev_valid, ev_slot, ev_ts, exp_q[0][7:6], exp_q[0][5:0]);
      end
      step(0, 0, 0, 0, 1, 0);
      guard++;
    end
    n_cmp++;
    if ({ev_valid, fifo_count} !== 5'd0) begin
      n_bad++;
      $display("[TB] FAIL b2b_empty got v=%b cnt=%0d want v=0 cnt=0", ev_valid, fifo_count);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    for (int i = 0; i < 64; i++) step(0, 0, 0, 1, 0, 0);
    step(1, 2'd1, 1, 0, 0, 0);
    n_cmp++;
    if ({ev_valid, ev_slot, ev_ts} !== {1'b1, 2'd1, 6'd0}) begin
      n_bad++;
      $display("[TB] FAIL ts_wrap got v=%b s=%0d ts=%0d want v=1 s=1 ts=0", ev_valid, ev_slot, ev_ts);
    end
    step(1, 2'd2, 1, 1, 0, 0);
    step(1, 2'd3, 1, 0, 0, 0);
    n_cmp++;
    if (fifo_count !== 4'd3) begin
      n_bad++;
      $display("[TB] FAIL three_queued got cnt=%0d want 3", fifo_count);
    end
    do_reset();
    n_cmp++;
    if ({ev_valid, fifo_count, overflow} !== 6'd0) begin
      n_bad++;
      $display("[TB] FAIL mid_reset got v=%b cnt=%0d ovf=%b want all 0", ev_valid, fifo_count, overflow);
    end
    step(0, 0, 0, 0, 1, 0);
    n_cmp++;
    if ({ev_valid, fifo_count} !== 5'd0) begin
      n_bad++;
      $display("[TB] FAIL post_reset_ready got v=%b cnt=%0d want 0", ev_valid, fifo_count);
    end
  endtask

  task automatic test_clear_precedence();
    for (int i = 0; i < 8; i++) step(1, 2'(i % 4), 1, 0, 0, 0);
    step(1, 2'd0, 1, 0, 0, 1);
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL clr_vs_drop got ovf=%b want 1", overflow);
    end
`ifdef AER_DROP_COUNT_EN
    n_cmp++;
    if (drop_count !== 8'd1) begin
      n_bad++;
      $display("[TB] FAIL clr_vs_drop_count got %0d want 1", drop_count);
    end
`endif
    for (int i = 0; i < 300; i++) step(1, 2'(i % 4), 1, 0, 0, 0);
    n_cmp++;
    if ({fifo_count, overflow} !== {4'd8, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL many_drops got cnt=%0d ovf=%b want cnt=8 ovf=1", fifo_count, overflow);
    end
`ifdef AER_DROP_COUNT_EN
    n_cmp++;
    if (drop_count !== 8'd255) begin
      n_bad++;
      $display("[TB] FAIL drop_saturate got %0d want 255 (model %0d)", drop_count, drop_model);
    end
`endif
    step(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL final_clear got ovf=%b want 0", overflow);
    end
  endtask

  initial begin
    rst_n = 1'b0; slot_valid = 1'b0; slot_in = '0; spike_in = 1'b0;
    frame_tick = 1'b0; ev_ready = 1'b0; clr_overflow = 1'b0;
    exp_q.delete(); ts_model = '0; ovf_model = 1'b0; drop_model = 0;
    @(posedge clk); #1;
    $display("[TB] starting spike_aer_encoder checks");
    test_reset();
    test_single_event();
    test_timestamp();
    test_fill_overflow();
    test_back_to_back();
    test_wrap_and_reset();
    test_clear_precedence();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spike_aer_encoder.md
Name: spike_aer_encoder

Overview:
- Downstream consumer of the time-multiplexed LIF neuron stage.
- Samples the neuron's spike output once per valid neuron slot.
- Converts each spike into an address-event word {slot index, frame timestamp} and buffers it in a FIFO.
- Drains the FIFO to the output pins over a valid/ready handshake, so the slow off-chip reader never stalls the neuron pipeline.

Parameters:
- NUM_SLOTS, 4: number of time-multiplexed neurons sharing one LIF core.
- SLOT_W, 2: width of the slot index; NUM_SLOTS must not exceed 2**SLOT_W.
- TS_W, 6: width of the frame timestamp counter.
- DEPTH, 8: FIFO depth in events; must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- slot_valid  input  1  spike_in/slot_in carry a valid neuron evaluation this cycle.
- slot_in  input  SLOT_W  index of the neuron currently evaluated by the LIF core.
- spike_in  input  1  LIF spike output for slot_in.
- frame_tick  input  1  single-cycle pulse marking the end of a full slot sweep.
- ev_ready  input  1  consumer accepts the head event this cycle.
- clr_overflow  input  1  clears the sticky overflow flag.
- ev_valid  output  1  head event present.
- ev_slot  output  SLOT_W  slot index of the head event.
- ev_ts  output  TS_W  timestamp of the head event.
- fifo_count  output  clog2(DEPTH)+1  events currently stored.
- overflow  output  1  sticky flag: at least one event was dropped.

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk. While rst_n=0 at a rising edge:
  - All outputs go to 0 (ev_valid, ev_slot, ev_ts, fifo_count, overflow).
  - Timestamp counter, FIFO read/write pointers and count go to 0.
  - FIFO contents are don't-care.
- Reset mid-operation: any stored events are discarded, with no partial pop.
- Timestamp counter:
  - Increments by 1 on each clk edge where frame_tick=1.
  - Wraps from 2**TS_W-1 to 0 with no flag.
- Event qualification and captured value:
  - push_req = slot_valid & spike_in.
  - The captured timestamp is the counter value before any same-cycle frame_tick increment.
  - slot_in is ignored when slot_valid=0.
- Level spikes: every qualified cycle produces one event. A neuron whose spike is held high produces one event per evaluation; there is no edge detection.
- FIFO organisation:
  - Show-ahead FIFO; ev_slot/ev_ts always reflect the head entry.
  - ev_valid = (count != 0).
  - Outputs are registered state, not combinational from the write port.
- Pop: pop = ev_valid & ev_ready.
  - ev_ready with ev_valid=0 has no effect.
  - Holding ev_ready high drains one event per cycle.
- Push: a push occurs when push_req & (count<DEPTH | pop).
  - When full, a simultaneous pop and push both succeed and count stays at DEPTH.
- Latency: a push into an empty FIFO makes ev_valid=1 with that event's data on the next clock edge (1 cycle).
- Ordering: strict FIFO order. Pointers wrap modulo DEPTH.
- fifo_count: count+push-pop, updated every edge, range 0..DEPTH.
- Overflow:
  - Set when push_req=1, count=DEPTH and pop=0; the event is discarded and FIFO contents are unchanged.
  - Cleared by clr_overflow=1.
  - If a set condition and clr_overflow occur in the same cycle, set wins and overflow stays 1.
- Handshake stability: while ev_valid=1 and ev_ready=0, ev_slot/ev_ts/ev_valid hold stable.

Optional Feature:
- Macro: AER_DROP_COUNT_EN.
- Defined:
  - Adds output drop_count [7:0].
  - drop_count increments on every discarded event and saturates at 255.
  - Reset and clr_overflow set it to 0; an increment coincident with clr_overflow wins, giving 1.
  - overflow = (drop_count != 0).
- Undefined:
  - No drop_count port and no counter logic.
  - overflow is a 1-bit sticky register as described in Behaviour.

Test Plan:
- Reset, then slot_valid=1, slot_in=2, spike_in=1 for one cycle, ev_ready=0 -> next cycle ev_valid=1, ev_slot=2, ev_ts=0, fifo_count=1; values hold stable for 5 cycles.
- Timestamp edge case: pulse frame_tick 3 times; then spike on slot 1 coincident with a 4th frame_tick -> event ev_ts=3. A subsequent spike on slot 0 -> ev_ts=4.
- Fill and overflow: ev_ready=0; push 8 spikes on slots 0,1,2,3,0,1,2,3 -> fifo_count=8, overflow=0. A 9th spike -> fifo_count=8, overflow=1. Drain with ev_ready=1 -> slots read out 0,1,2,3,0,1,2,3, then ev_valid=0.
- Full with simultaneous pop and push: FIFO full, ev_ready=1 and spike on slot 3 in the same cycle -> fifo_count stays 8, overflow=0, new event appears last on drain.
- Wrap and reset: set TS_W=6 and pulse frame_tick 64 times, then spike -> ev_ts=0. With 3 events queued, assert rst_n=0 for 1 cycle -> ev_valid=0, fifo_count=0, overflow=0.
- Clear precedence (repeat with AER_DROP_COUNT_EN defined): clr_overflow=1 in the same cycle as a dropped event -> overflow=1, drop_count=1. Drop 300 events -> drop_count=255.
